cond_unit: RTL
==============

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk  in  1  rising-edge clock`; `reset_n  in  1  asynchronous active-low reset`.
REQ-002 The block SHALL have the following ports:
- `valid_in  in  1  decoded instruction present this cycle`
- `stall  in  1  hold pipeline stage; no state change except reset`
- `flush  in  1  squash the stage output`
- `cond  in  4  ARM-style condition field`
- `alu_flags  in  4  {N,Z,C,V} from the ALU for the current instruction`
- `flag_w  in  2  bit1 = update N,Z; bit0 = update C,V`
- `pc_s, reg_w, mem_w  in  1 each  requested side effects`
- `no_write  in  1  compare-type op; suppress reg_w`
- `valid_q  out  1  registered output valid`
- `pc_src_q, reg_write_q, mem_write_q  out  1 each  gated, registered side effects`
- `cond_ex_q  out  1  registered condition-passed`
- `flags_q  out  4  architectural {N,Z,C,V} register`
- `illegal_cond_q  out  1  registered pulse, cond == 4'b1111 seen`

Function
REQ-003 cond_ex SHALL be computed combinationally from `cond` and the current `flags_q`, never from `alu_flags`.
REQ-004 The condition codes SHALL decode as follows:
- EQ 0000: Z
- NE 0001: !Z
- CS 0010: C
- CC 0011: !C
- MI 0100: N
- PL 0101: !N
- VS 0110: V
- VC 0111: !V
- HI 1000: C & !Z
- LS 1001: !C | Z
- GE 1010: N == V
- LT 1011: N != V
- GT 1100: !Z & (N == V)
- LE 1101: Z | (N != V)
- AL 1110: 1
- 1111: 0, and flagged illegal
REQ-005 An instruction SHALL be accepted on a rising edge when `valid_in` = 1, `stall` = 0 and `flush` = 0.
REQ-006 On acceptance, the registered outputs SHALL update as follows, with 1-cycle latency:
- `valid_q` = 1
- `cond_ex_q` = cond_ex
- `pc_src_q` = pc_s & cond_ex
- `reg_write_q` = reg_w & cond_ex & !no_write
- `mem_write_q` = mem_w & cond_ex
- `illegal_cond_q` = (cond == 4'b1111)
REQ-007 On acceptance with cond_ex = 1, `flags_q[3:2]` SHALL load `alu_flags[3:2]` iff `flag_w[1]`, and `flags_q[1:0]` SHALL load `alu_flags[1:0]` iff `flag_w[0]`; unselected bits hold.
REQ-008 On acceptance with cond_ex = 0, `flags_q` SHALL hold and all side-effect outputs SHALL be 0, while `valid_q` = 1.
REQ-009 When `valid_in` = 0, `stall` = 0 and `flush` = 0, the next state SHALL be `valid_q` = 0, all side-effect outputs 0, `illegal_cond_q` = 0, and `flags_q` held.
REQ-010 When `stall` = 1 and `flush` = 0, every register including `flags_q` SHALL hold its value; inputs are ignored.
REQ-011 When `flush` = 1, regardless of `stall` or `valid_in`, the next state SHALL be `valid_q` = 0, all side-effect outputs 0, `cond_ex_q` = 0, `illegal_cond_q` = 0, and `flags_q` held (no flag update from a squashed instruction).
REQ-012 For back-to-back accepted instructions, the second instruction's condition SHALL see flags written by the first; there is no same-cycle bypass, and the registered update suffices.
REQ-013 `illegal_cond_q` SHALL be a single-cycle pulse per accepted illegal instruction, and the instruction SHALL have no side effects and no flag update.
REQ-014 Outputs SHALL be glitch-free registered values; no output may combinationally depend on inputs.

Reset
REQ-015 While `reset_n` = 0, all outputs SHALL be forced immediately (asynchronously) to: `flags_q` = 4'b0000, `valid_q` = 0, `cond_ex_q` = 0, `pc_src_q` = 0, `reg_write_q` = 0, `mem_write_q` = 0, `illegal_cond_q` = 0.
REQ-016 Reset asserted mid-stall or mid-instruction SHALL discard the in-flight instruction, and the first acceptance after release SHALL evaluate against flags = 0000 (e.g. EQ fails, NE passes).
REQ-017 Release of `reset_n` SHALL take effect at the first rising `clk` edge after deassertion.

Verification
REQ-018 Reset then accept NE (0001) with `reg_w` = 1, `flag_w` = 11, `alu_flags` = 0100 -> next cycle `reg_write_q` = 1, `cond_ex_q` = 1, `flags_q` = 0100.
REQ-019 Following REQ-018, accept EQ (0000) with `mem_w` = 1, `flag_w` = 00 -> `mem_write_q` = 1; then NE with `pc_s` = 1 -> `pc_src_q` = 0, `valid_q` = 1, `flags_q` still 0100.
REQ-020 Partial update: `flags_q` = 1111, accept AL, `flag_w` = 10, `alu_flags` = 0000 -> `flags_q` = 0011; then GE -> `cond_ex_q` = 0 (N=0 == V=1 false); then CS -> `cond_ex_q` = 1.
REQ-021 Stall and flush:
- Hold `stall` = 1 for 3 cycles with varying inputs -> all outputs constant.
- Assert `stall` = 1 and `flush` = 1 together with an AL/`flag_w` = 11 instruction -> `valid_q` = 0 and `flags_q` unchanged.
REQ-022 Accept cond = 1111 with `reg_w` = 1, `flag_w` = 11 -> `illegal_cond_q` = 1 for exactly one cycle, `reg_write_q` = 0, `flags_q` unchanged.
REQ-023 Reset mid-operation: assert `reset_n` = 0 between clock edges while `valid_q` = 1 and `flags_q` = 1010 -> outputs zero immediately; after release, accept EQ -> `cond_ex_q` = 0.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: ARM-style condition evaluation and flag register for one pipeline stage.
//
// Evaluates the 4-bit condition field against the architectural flags register,
// gates the requested side effects with the result, and updates the flags from
// the ALU when the instruction is accepted and its condition passes.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   valid_in            decoded instruction present this cycle
//   stall               hold every register (flush has priority)
//   flush               squash this stage's output; flags never update
//   cond                condition field
//   alu_flags           {N,Z,C,V} produced by the ALU for this instruction
//   flag_w              bit1 enables N,Z update; bit0 enables C,V update
//   pc_s, reg_w, mem_w  requested side effects
//   no_write            compare-type op, suppresses the register write
//   valid_q             registered valid
//   pc_src_q, reg_write_q, mem_write_q  gated side effects
//   cond_ex_q           registered condition-passed
//   flags_q             architectural {N,Z,C,V}
//   illegal_cond_q      one-cycle pulse for an accepted cond == 4'b1111
module cond_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pc_s,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       valid_q,
  output logic       pc_src_q,
  output logic       reg_write_q,
  output logic       mem_write_q,
  output logic       cond_ex_q,
  output logic [3:0] flags_q,
  output logic       illegal_cond_q
);

  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex;
  logic       illegal;
  logic       accept;

  logic       valid_d;
  logic       pc_src_d;
  logic       reg_write_d;
  logic       mem_write_d;
  logic       cond_ex_d;
  logic [3:0] flags_d;
  logic       illegal_cond_d;

  // Condition is evaluated against the committed flags only; the ALU result of the
  // current instruction is never visible to its own condition.
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  assign illegal = (cond == 4'b1111);
  assign accept  = valid_in & ~stall & ~flush;

  always_comb begin
    // Default: hold everything (covers stall without flush).
    valid_d        = valid_q;
    pc_src_d       = pc_src_q;
    reg_write_d    = reg_write_q;
    mem_write_d    = mem_write_q;
    cond_ex_d      = cond_ex_q;
    flags_d        = flags_q;
    illegal_cond_d = illegal_cond_q;

    if (flush || (!stall && !valid_in)) begin
      // Bubble: squashed or empty slot, flags untouched.
      valid_d        = 1'b0;
      pc_src_d       = 1'b0;
      reg_write_d    = 1'b0;
      mem_write_d    = 1'b0;
      cond_ex_d      = 1'b0;
      illegal_cond_d = 1'b0;
    end else if (accept) begin
      valid_d        = 1'b1;
      cond_ex_d      = cond_ex;
      pc_src_d       = pc_s & cond_ex;
      reg_write_d    = reg_w & cond_ex & ~no_write;
      mem_write_d    = mem_w & cond_ex;
      illegal_cond_d = illegal;
      if (cond_ex) begin
        if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= 1'b0;
      pc_src_q       <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      cond_ex_q      <= 1'b0;
      flags_q        <= 4'b0000;
      illegal_cond_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      pc_src_q       <= pc_src_d;
      reg_write_q    <= reg_write_d;
      mem_write_q    <= mem_write_d;
      cond_ex_q      <= cond_ex_d;
      flags_q        <= flags_d;
      illegal_cond_q <= illegal_cond_d;
    end
  end

endmodule
